// File: rtl/pchri03_pkg.sv
// Shared types for the pchri03 UART transmit path.
// Provides the TX FSM state enum and the frame data width.
package pchri03_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/pchri03_uart_tx_if.sv
// Byte handshake from the core into the UART transmitter.
// master: drives in_data/in_valid; slave: returns in_ready.
interface pchri03_uart_tx_if;
    import pchri03_pkg::*;

    logic [UART_DATA_BITS-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/pchri03_sync_fifo.sv
// Circular-buffer FIFO with a count register, single clock.
// Ports: push/wdata write, pop/rdata read, full, empty, count.
module pchri03_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Full blocks a push even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pchri03_uart_tx.sv
// Buffered 8N1 UART transmitter for the pchri03 chip output.
// Ports: clk, rst_n, ena, bus (byte handshake), tx line, busy.
module pchri03_uart_tx
    import pchri03_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    pchri03_uart_tx_if.slave   bus,
    output logic               tx,
    output logic               busy
);

    localparam int BW = $clog2(CLK_DIV + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(UART_DATA_BITS - 1);

    uart_state_t               state_q, state_d;
    logic [BW-1:0]             baud_q, baud_d;
    logic [NW-1:0]             bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                      tx_q, tx_d;

    logic                      push;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic [CW-1:0]             fifo_count;
    logic [UART_DATA_BITS-1:0] rdata;
    logic                      baud_end;

    assign bus.in_ready = ena && !full;
    assign push         = bus.in_valid && bus.in_ready;
    assign baud_end     = (baud_q == BAUD_LAST);
    assign tx           = tx_q;
    assign busy         = (state_q != IDLE) || (fifo_count != '0);

    pchri03_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_data),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // tx_d is the line level for the state being entered, so the
    // line comes straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = rdata;
                        baud_d  = '0;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                        tx_d    = shreg_q[0];
                    end else begin
                        baud_d = baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_d = '0;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            bit_d   = bit_q + NW'(1);
                            shreg_d = shreg_q >> 1;
                            tx_d    = shreg_q[1];
                        end
                    end else begin
                        baud_d = baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_d = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            shreg_d = rdata;
                            state_d = START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        baud_d = baud_q + BW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_pchri03_uart_tx.sv
// Directed bench for pchri03_uart_tx with CLK_DIV=4, DEPTH=4.
// Captures the tx line per cycle and compares whole frames.
module tb_pchri03_uart_tx;
    import pchri03_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int FL      = 10 * CLK_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;
    logic tx;
    logic busy;

    pchri03_uart_tx_if bus ();

    pchri03_uart_tx #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic       s_tx   [0:399];
    logic       s_busy [0:399];
    logic [7:0] tbytes [0:31];
    int         acc_cyc [0:15];
    logic       rdy_after [0:15];

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line level per cycle for one frame: start, LSB-first data, stop.
    function automatic logic [39:0] exp_frame(input logic [7:0] d);
        logic [39:0] v;
        int b;
        v = '0;
        for (int i = 0; i < FL; i++) begin
            b = i / CLK_DIV;
            if (b == 0)      v[i] = 1'b0;
            else if (b == 9) v[i] = 1'b1;
            else             v[i] = d[b-1];
        end
        return v;
    endfunction

    task automatic run_frames(input string tag, input int first,
                              input int n);
        logic [39:0] got;
        logic acc;
        int waitc;
        bus.in_valid = 1'b1;
        bus.in_data  = tbytes[first];
        check({tag, "_rdy0"}, bus.in_ready, 1);
        step();
        acc_cyc[0]   = cyc;
        rdy_after[0] = bus.in_ready;
        fork
            begin
                for (int idx = 1; idx < n; idx++) begin
                    bus.in_data = tbytes[first+idx];
                    waitc = 0;
                    do begin
                        acc = bus.in_ready;
                        step();
                        waitc++;
                    end while (!acc && waitc < 500);
                    if (!acc) begin
                        check({tag, "_push_timeout"}, 0, 1);
                        break;
                    end
                    acc_cyc[idx]   = cyc;
                    rdy_after[idx] = bus.in_ready;
                end
                bus.in_valid = 1'b0;
            end
            begin
                step();
                for (int i = 0; i < n * FL; i++) begin
                    s_tx[i]   = tx;
                    s_busy[i] = busy;
                    step();
                end
            end
        join
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < FL; i++) got[i] = s_tx[f*FL+i];
            check($sformatf("%s_frame%0d", tag, f), got,
                  exp_frame(tbytes[first+f]));
        end
        check({tag, "_busy_last"}, s_busy[n*FL-1], 1);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [39:0] rf;
        logic e;

        tbytes[0] = 8'hA5;
        for (int i = 1; i <= 6; i++) tbytes[i] = 8'(i);
        tbytes[8]  = 8'h3C; tbytes[9]  = 8'hC3;
        tbytes[10] = 8'h81; tbytes[11] = 8'h7E;
        tbytes[12] = 8'h0F; tbytes[13] = 8'hF0;
        tbytes[14] = 8'h55; tbytes[15] = 8'hAA;
        tbytes[16] = 8'h99; tbytes[17] = 8'h66;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst_n = 1'b0;
        ena   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rdy", bus.in_ready, 1);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_tx_high", bad, 0);

        run_frames("single", 0, 1);

        run_frames("burst", 1, 6);
        check("burst_5_consec", acc_cyc[4] - acc_cyc[0], 4);
        check("burst_rdy_full", rdy_after[4], 0);

        // 0x5A with ena low for 10 cycles inside data bit 3.
        rf = exp_frame(8'h5A);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        step();
        bus.in_valid = 1'b0;
        step();
        for (int i = 0; i < 50; i++) begin
            s_tx[i] = tx;
            if (i == 17) ena = 1'b0;
            if (i == 20) check("stall_rdy", bus.in_ready, 0);
            if (i == 27) ena = 1'b1;
            step();
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (i <= 17)      e = rf[i];
            else if (i <= 27) e = rf[17];
            else              e = rf[i-10];
            if (s_tx[i] !== e) bad++;
        end
        check("stall_bits", bad, 0);
        bad = 0;
        for (int i = 18; i <= 27; i++) if (s_tx[i] !== s_tx[17]) bad++;
        check("stall_hold", bad, 0);
        check("stall_busy_end", busy, 0);

        // Frame of 0x00 in flight, two more bytes queued.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        step();
        bus.in_data  = 8'h12;
        step();
        bus.in_data  = 8'h34;
        step();
        bus.in_valid = 1'b0;
        repeat (12) step();
        check("mrst_pre_tx", tx, 0);
        check("mrst_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_tx", tx, 1);
        check("mrst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("mrst_quiet", bad, 0);

        run_frames("wrap_g0", 8, 3);
        run_frames("wrap_g1", 11, 3);
        run_frames("wrap_g2", 14, 3);
        run_frames("wrap_g3", 17, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
